// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard scoreboard.
// Latency codes name how many cycles a result needs before it can be forwarded.
package hazard_pkg;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 4;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_RAW,
        HZ_WAW,
        HZ_STRUCT
    } hazard_cause_t;

endpackage

// File: rtl/hazard_reg_timer.sv
// Single down-counter tracking the cycles until one pending result is forwardable.
// A load in the same cycle wins over the decrement.
module hazard_reg_timer #(
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            load,
    input  logic [LATW-1:0] loadVal,
    output logic [LATW-1:0] count
);

    always_ff @(posedge clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: per-register latency timers plus a Hi/Lo occupancy timer,
// producing a zero-latency stall for RAW, WAW and multiplier structural hazards.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter int REGW    = 5,
    parameter int MAX_LAT = 7,
    parameter int LATW    = 3,
    parameter int MUL_LAT = LAT_MUL,
    parameter int STATW   = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [REGW-1:0]  id_rs,
    input  logic [REGW-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REGW-1:0]  id_dest,
    input  logic             id_writes,
    input  logic [LATW-1:0]  id_lat,
    input  logic             id_is_mul,
    output logic             pc_write,
    output logic             ifid_enable,
    output logic             bubble,
    output logic             id_accept,
    output logic [NREGS-1:0] busy_vec,
    output logic [STATW-1:0] stall_count
);

    function automatic logic [LATW-1:0] clampLat(input logic [LATW-1:0] lat);
        if (int'(lat) > MAX_LAT) begin
            return LATW'(MAX_LAT);
        end
        return lat;
    endfunction

    function automatic logic [STATW-1:0] satInc(input logic [STATW-1:0] value);
        if (&value) begin
            return value;
        end
        return value + 1'b1;
    endfunction

    logic [NREGS-1:0][LATW-1:0] cnt;
    logic [LATW-1:0]            mulBusy;
    logic [LATW-1:0]            latC;
    logic                       rawHaz;
    logic                       wawHaz;
    logic                       structHaz;
    logic                       stall;
    logic                       live;

    assign latC = clampLat(id_lat);

    // A squashed or absent instruction never stalls; reset also holds the pipe open.
    assign live      = id_valid & ~id_flush & ~Reset;
    assign rawHaz    = (id_use_rs & (id_rs != '0) & (cnt[id_rs] != '0))
                     | (id_use_rt & (id_rt != '0) & (cnt[id_rt] != '0));
    assign wawHaz    = id_writes & (id_dest != '0) & (cnt[id_dest] > latC);
    assign structHaz = id_is_mul & (mulBusy != '0);
    assign stall     = live & (rawHaz | wawHaz | structHaz);

    assign id_accept   = live & ~stall;
    assign pc_write    = ~stall;
    assign ifid_enable = ~stall;
    assign bubble      = stall;

    assign cnt[0]      = '0;
    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : gReg
        logic loadReg;
        assign loadReg = id_accept & id_writes & (id_dest == REGW'(r));

        hazard_reg_timer #(.LATW(LATW)) uTimer (
            .clk     (clk),
            .Reset   (Reset),
            .load    (loadReg),
            .loadVal (latC),
            .count   (cnt[r])
        );

        assign busy_vec[r] = (cnt[r] != '0);
    end

    hazard_reg_timer #(.LATW(LATW)) uMulTimer (
        .clk     (clk),
        .Reset   (Reset),
        .load    (id_accept & id_is_mul),
        .loadVal (LATW'(MUL_LAT)),
        .count   (mulBusy)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_count <= '0;
        end else if (stall) begin
            stall_count <= satInc(stall_count);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: per-cycle expected stall/accept are queued
// with the stimulus and checked on the falling edge; state checks are inline.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NREGS = 32;
    localparam int REGW  = 5;
    localparam int LATW  = 3;
    localparam int STATW = 10;

    logic             clk = 1'b0;
    logic             Reset;
    logic             id_valid, id_flush, id_use_rs, id_use_rt, id_writes, id_is_mul;
    logic [REGW-1:0]  id_rs, id_rt, id_dest;
    logic [LATW-1:0]  id_lat;
    logic             pc_write, ifid_enable, bubble, id_accept;
    logic [NREGS-1:0] busy_vec;
    logic [STATW-1:0] stall_count;

    typedef struct {
        logic          stall;
        logic          accept;
        hazard_cause_t cause;
    } exp_t;

    exp_t expQ[$];
    int   nVec = 0;
    int   nBad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREGS(NREGS), .REGW(REGW), .MAX_LAT(7), .LATW(LATW),
                        .MUL_LAT(LAT_MUL), .STATW(STATW)) dut (
        .clk(clk), .Reset(Reset), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dest(id_dest), .id_writes(id_writes), .id_lat(id_lat), .id_is_mul(id_is_mul),
        .pc_write(pc_write), .ifid_enable(ifid_enable), .bubble(bubble),
        .id_accept(id_accept), .busy_vec(busy_vec), .stall_count(stall_count)
    );

    // Scoreboard: one queued expectation per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            nVec++;
            if ({pc_write, ifid_enable, bubble, id_accept} !==
                {~e.stall, ~e.stall, e.stall, e.accept}) begin
                nBad++;
                $display("FAIL ctl[%s] t=%0t got pc=%b ifid=%b bubble=%b acc=%b, want stall=%b acc=%b",
                         e.cause.name(), $time, pc_write, ifid_enable, bubble, id_accept,
                         e.stall, e.accept);
            end
        end
    end

    task automatic setIn(input logic v, input logic f, input int rs, input int rt,
                         input logic urs, input logic urt, input int dest,
                         input logic wr, input int lat, input logic mul);
        id_valid  = v;
        id_flush  = f;
        id_rs     = REGW'(rs);
        id_rt     = REGW'(rt);
        id_use_rs = urs;
        id_use_rt = urt;
        id_dest   = REGW'(dest);
        id_writes = wr;
        id_lat    = LATW'(lat);
        id_is_mul = mul;
    endtask

    task automatic pushExp(input logic s, input logic a, input hazard_cause_t c);
        exp_t e;
        e.stall  = s;
        e.accept = a;
        e.cause  = c;
        expQ.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            pushExp(1'b0, 1'b0, HZ_NONE);
            step();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        setIn(1, 0, 0, 0, 0, 0, 2, 1, 1, 1);
        pushExp(1'b0, 1'b0, HZ_NONE);
        step();
        pushExp(1'b0, 1'b0, HZ_NONE);
        step();
        nVec++;
        if (busy_vec !== '0 || stall_count !== '0) begin
            nBad++;
            $display("FAIL reset_state got busy=%h cnt=%0d, want busy=0 cnt=0", busy_vec, stall_count);
        end
        Reset = 1'b0;
        idle(1);
    endtask

    task automatic test_load_use();
        setIn(1, 0, 0, 0, 0, 0, 2, 1, LAT_LOAD, 0);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(1, 0, 2, 4, 1, 1, 3, 1, LAT_ALU, 0);
        nVec++;
        if (busy_vec[2] !== 1'b1) begin
            nBad++;
            $display("FAIL load_use_busy_r2 got %b, want 1", busy_vec[2]);
        end
        pushExp(1'b1, 1'b0, HZ_RAW);
        step();
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        nVec++;
        if (stall_count !== STATW'(1) || busy_vec !== '0) begin
            nBad++;
            $display("FAIL load_use_stats got cnt=%0d busy=%h, want cnt=1 busy=0", stall_count, busy_vec);
        end
        idle(1);
    endtask

    task automatic test_mul_use();
        setIn(1, 0, 1, 2, 1, 1, 5, 1, LAT_MUL, 1);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(1, 0, 5, 0, 1, 0, 6, 1, LAT_ALU, 0);
        for (int i = 0; i < 4; i++) begin
            pushExp(1'b1, 1'b0, HZ_RAW);
            step();
        end
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        nVec++;
        if (stall_count !== STATW'(5) || busy_vec !== '0) begin
            nBad++;
            $display("FAIL mul_use_stats got cnt=%0d busy=%h, want cnt=5 busy=0", stall_count, busy_vec);
        end
    endtask

    task automatic test_back_to_back();
        setIn(1, 0, 8, 9, 1, 1, 10, 1, LAT_MUL, 1);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(1, 0, 11, 12, 1, 1, 13, 1, LAT_MUL, 1);
        nVec++;
        if (busy_vec[11] !== 1'b0 || busy_vec[12] !== 1'b0) begin
            nBad++;
            $display("FAIL b2b_src_busy got r11=%b r12=%b, want 0 0", busy_vec[11], busy_vec[12]);
        end
        for (int i = 0; i < 4; i++) begin
            pushExp(1'b1, 1'b0, HZ_STRUCT);
            step();
        end
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        nVec++;
        if (stall_count !== STATW'(9) || busy_vec[13] !== 1'b1) begin
            nBad++;
            $display("FAIL b2b_stats got cnt=%0d r13=%b, want cnt=9 r13=1", stall_count, busy_vec[13]);
        end
        idle(4);
        nVec++;
        if (busy_vec !== '0) begin
            nBad++;
            $display("FAIL b2b_drain got busy=%h, want 0", busy_vec);
        end
    endtask

    task automatic test_waw();
        setIn(1, 0, 0, 0, 0, 0, 7, 1, 4, 0);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(1, 0, 0, 0, 0, 0, 7, 1, LAT_ALU, 0);
        for (int i = 0; i < 4; i++) begin
            pushExp(1'b1, 1'b0, HZ_WAW);
            step();
        end
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        nVec++;
        if (busy_vec[7] !== 1'b0) begin
            nBad++;
            $display("FAIL waw_alu_dest got r7=%b, want 0", busy_vec[7]);
        end
        setIn(1, 0, 0, 0, 0, 0, 7, 1, 4, 0);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(1, 0, 0, 0, 0, 0, 7, 1, 3, 0);
        pushExp(1'b1, 1'b0, HZ_WAW);
        step();
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        nVec++;
        if (busy_vec[7] !== 1'b1 || stall_count !== STATW'(14)) begin
            nBad++;
            $display("FAIL waw_partial got r7=%b cnt=%0d, want r7=1 cnt=14", busy_vec[7], stall_count);
        end
        idle(3);
        nVec++;
        if (busy_vec !== '0) begin
            nBad++;
            $display("FAIL waw_drain got busy=%h, want 0", busy_vec);
        end
    endtask

    task automatic test_flush_r0();
        setIn(1, 0, 0, 0, 0, 0, 2, 1, LAT_LOAD, 0);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(1, 1, 2, 0, 1, 0, 3, 1, LAT_ALU, 0);
        pushExp(1'b0, 1'b0, HZ_NONE);
        nVec++;
        if (busy_vec[2] !== 1'b1) begin
            nBad++;
            $display("FAIL flush_busy_r2 got %b, want 1", busy_vec[2]);
        end
        step();
        setIn(1, 1, 0, 0, 0, 0, 6, 1, 4, 1);
        pushExp(1'b0, 1'b0, HZ_NONE);
        step();
        nVec++;
        if (busy_vec !== '0) begin
            nBad++;
            $display("FAIL flush_no_update got busy=%h, want 0", busy_vec);
        end
        setIn(1, 0, 0, 0, 1, 1, 0, 1, 4, 0);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        nVec++;
        if (busy_vec[0] !== 1'b0) begin
            nBad++;
            $display("FAIL r0_busy got %b, want 0", busy_vec[0]);
        end
        setIn(1, 0, 0, 0, 0, 0, 9, 1, 3, 0);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(0, 0, 9, 9, 1, 1, 0, 0, 0, 0);
        pushExp(1'b0, 1'b0, HZ_NONE);
        step();
        nVec++;
        if (busy_vec[9] !== 1'b1) begin
            nBad++;
            $display("FAIL invalid_keeps_r9 got %b, want 1", busy_vec[9]);
        end
        idle(2);
        nVec++;
        if (busy_vec[9] !== 1'b0 || stall_count !== STATW'(14)) begin
            nBad++;
            $display("FAIL invalid_decay got r9=%b cnt=%0d, want r9=0 cnt=14", busy_vec[9], stall_count);
        end
    endtask

    task automatic test_reset_mid_stall();
        setIn(1, 0, 0, 0, 0, 0, 5, 1, LAT_MUL, 1);
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
        setIn(1, 0, 5, 0, 1, 0, 0, 0, 0, 0);
        pushExp(1'b1, 1'b0, HZ_RAW);
        step();
        pushExp(1'b1, 1'b0, HZ_RAW);
        step();
        Reset = 1'b1;
        pushExp(1'b0, 1'b0, HZ_NONE);
        step();
        nVec++;
        if (busy_vec !== '0 || stall_count !== '0) begin
            nBad++;
            $display("FAIL reset_mid_stall got busy=%h cnt=%0d, want 0 0", busy_vec, stall_count);
        end
        Reset = 1'b0;
        pushExp(1'b0, 1'b1, HZ_NONE);
        step();
    endtask

    task automatic test_saturate();
        int stalls;
        logic [STATW-1:0] want;
        stalls = 0;
        setIn(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 1300; i++) begin
            if (i % 5 == 0) begin
                pushExp(1'b0, 1'b1, HZ_NONE);
            end else begin
                pushExp(1'b1, 1'b0, HZ_STRUCT);
                stalls++;
            end
            step();
            if (i == 99 || i == 1299) begin
                want = (stalls >= (1 << STATW)) ? '1 : STATW'(stalls);
                nVec++;
                if (stall_count !== want) begin
                    nBad++;
                    $display("FAIL saturate_at_%0d got %0d, want %0d", i, stall_count, want);
                end
            end
        end
        idle(5);
    endtask

    initial begin
        Reset = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        test_reset();
        test_load_use();
        test_mul_use();
        test_back_to_back();
        test_waw();
        test_flush_r0();
        test_reset_mid_stall();
        test_saturate();
        step();
        nVec++;
        if (expQ.size() != 0) begin
            nBad++;
            $display("FAIL queue_drain got %0d pending, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
